// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Glyph codes are active-low segment patterns, bit0=a .. bit6=g.
package sevenseg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } state_t;

endpackage

// File: rtl/sevenseg_scan_decoder_if.sv
// Bus between a display scanner and the decoder: digit strobes,
// segments and dp in; decoded frame out with valid/ready.
interface sevenseg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);

  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic                    out_ready;
  logic [4*NUM_DIGITS-1:0] hex_out;
  logic [NUM_DIGITS-1:0]   dp_out;
  logic [NUM_DIGITS-1:0]   err_out;
  logic                    out_valid;
  logic                    overflow;

  modport master (
    output digit_sel, seg_n, dp_n, out_ready,
    input  hex_out, dp_out, err_out,
    input  out_valid, overflow
  );

  modport slave (
    input  digit_sel, seg_n, dp_n, out_ready,
    output hex_out, dp_out, err_out,
    output out_valid, overflow
  );

endinterface

// File: rtl/sevenseg_glyph_decode.sv
// Glyph to nibble decoder: seg_n -> {err, nibble}.
// Unknown patterns (including blank) give nibble 0 with err set.
module sevenseg_glyph_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic       err,
  output logic [3:0] nibble
);

  always_comb begin
    err    = 1'b0;
    nibble = 4'h0;
    case (seg_n)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Debounces a multiplexed seven-segment bus and assembles frames.
// Ports: clk, rst (sync, high), bus (slave side of the scan bus).
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input logic clk,
  input logic rst,
  sevenseg_scan_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = NUM_DIGITS + 8;
  localparam int HW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] TARGET = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [SW-1:0] cur;
  logic [SW-1:0] prev;
  logic          onehot;
  logic          same;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          capture;

  logic          dec_err;
  logic [3:0]    dec_nib;

  logic [HW-1:0]         stg_hex;
  logic [HW-1:0]         hex_nx;
  logic [NUM_DIGITS-1:0] stg_dp;
  logic [NUM_DIGITS-1:0] dp_nx;
  logic [NUM_DIGITS-1:0] stg_err;
  logic [NUM_DIGITS-1:0] err_nx;
  logic [NUM_DIGITS-1:0] mask;
  logic [NUM_DIGITS-1:0] mask_nx;
  logic                  full;

  logic [HW-1:0]         hex_q;
  logic [NUM_DIGITS-1:0] dp_q;
  logic [NUM_DIGITS-1:0] err_q;
  logic                  valid_q;
  logic                  ovf_q;

  assign cur  = {bus.digit_sel, bus.seg_n, bus.dp_n};
  assign same = (cur == prev);
  assign onehot = (bus.digit_sel != '0) &&
    ((bus.digit_sel &
      (bus.digit_sel - NUM_DIGITS'(1))) == '0);

  sevenseg_glyph_decode u_dec (
    .seg_n  (bus.seg_n),
    .err    (dec_err),
    .nibble (dec_nib)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      prev  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      prev  <= cur;
    end
  end

  // Any change of the full sample restarts the stability run.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!onehot) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == CAPTURED && same) begin
      state_n = CAPTURED;
    end else begin
      if (state == SETTLE && same) cnt_n = cnt + ONE_C;
      else cnt_n = ONE_C;
      if (cnt_n == TARGET) state_n = CAPTURED;
      else state_n = SETTLE;
    end
  end

  // Capture only on the transition into CAPTURED.
  always_comb begin
    capture = (state_n == CAPTURED) &&
              !(state == CAPTURED && same);
  end

  always_comb begin
    hex_nx  = stg_hex;
    dp_nx   = stg_dp;
    err_nx  = stg_err;
    mask_nx = mask;
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bus.digit_sel[i]) begin
          hex_nx[4*i +: 4] = dec_nib;
          dp_nx[i]         = ~bus.dp_n;
          err_nx[i]        = dec_err;
        end
      end
      mask_nx = mask | bus.digit_sel;
    end
    full = capture && (mask_nx == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_hex <= '0;
      stg_dp  <= '0;
      stg_err <= '0;
      mask    <= '0;
      hex_q   <= '0;
      dp_q    <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      stg_hex <= hex_nx;
      stg_dp  <= dp_nx;
      stg_err <= err_nx;
      mask    <= full ? '0 : mask_nx;
      if (full) begin
        if (!valid_q || bus.out_ready) begin
          hex_q   <= hex_nx;
          dp_q    <= dp_nx;
          err_q   <= err_nx;
          valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.hex_out   = hex_q;
  assign bus.dp_out    = dp_q;
  assign bus.err_out   = err_q;
  assign bus.out_valid = valid_q;
  assign bus.overflow  = ovf_q;

endmodule
